// File: rtl/nibble_add_seq.sv
// Wide adder sequencer: drives an external 4-bit ripple-carry stage one nibble per clock,
// LSB first, chaining the carry and presenting the wide result over valid/ready.
module nibble_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   op_cin,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout,
   output logic [4*NIBBLES-1:0]   res,
   output logic                   res_cout,
   output logic                   res_ovf,
   output logic                   res_valid,
   input  logic                   res_ready
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  res_reg;
   logic          carry_reg;
   logic          last;

   // Mux-free nibble select: OR together the slice whose index matches.
   function automatic logic [3:0] nib(input logic [W-1:0] v, input logic [CW-1:0] idx);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < NIBBLES; i++) begin
         n = n | (v[4*i +: 4] & {4{idx == CW'(i)}});
      end
      return n;
   endfunction

   assign last = (cnt == CW'(NIBBLES - 1));
   assign res  = res_reg;

   // Output decode from the registered state only.
   always_comb begin
      in_ready  = 1'b0;
      add_a     = 4'd0;
      add_b     = 4'd0;
      add_cin   = 1'b0;
      res_valid = 1'b0;
      res_cout  = 1'b0;
      res_ovf   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
         end
         RUN: begin
            add_a   = nib(a_reg, cnt);
            add_b   = nib(b_reg, cnt);
            add_cin = carry_reg;
         end
         DONE: begin
            res_valid = 1'b1;
            res_cout  = carry_reg;
            res_ovf   = (a_reg[W-1] == b_reg[W-1]) && (res_reg[W-1] != a_reg[W-1]);
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Sequencer state, operand capture and nibble-wise result accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  carry_reg <= op_cin;
                  cnt       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (cnt == CW'(i)) begin
                     res_reg[4*i +: 4] <= add_sum;
                  end
               end
               carry_reg <= add_cout;
               if (last) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: 16-bit and 8-bit builds, each driving a behavioural 4-bit adder.
module tb_nibble_add_seq;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        o;
   } exp4_t;

   typedef struct packed {
      logic [7:0] r;
      logic       c;
      logic       o;
   } exp2_t;

   logic clk;
   logic rst;

   logic        in_valid, in_ready, op_cin, add_cin, add_cout, res_cout, res_ovf, res_valid, res_ready;
   logic [15:0] op_a, op_b, res;
   logic [3:0]  add_a, add_b, add_sum;

   logic        in_valid2, in_ready2, op_cin2, add_cin2, add_cout2, res_cout2, res_ovf2, res_valid2, res_ready2;
   logic [7:0]  op_a2, op_b2, res2;
   logic [3:0]  add_a2, add_b2, add_sum2;

   int    tests = 0;
   int    fails = 0;
   bit    bp = 1'b0;
   exp4_t q4[$];
   exp2_t q2[$];
   exp4_t m4_e;
   exp2_t m2_e;

   nibble_add_seq #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .res(res), .res_cout(res_cout), .res_ovf(res_ovf),
      .res_valid(res_valid), .res_ready(res_ready)
   );

   nibble_add_seq #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .op_a(op_a2), .op_b(op_b2), .op_cin(op_cin2),
      .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
      .add_sum(add_sum2), .add_cout(add_cout2),
      .res(res2), .res_cout(res_cout2), .res_ovf(res_ovf2),
      .res_valid(res_valid2), .res_ready(res_ready2)
   );

   // The external 4-bit ripple-carry stages.
   assign {add_cout,  add_sum}  = 5'(add_a)  + 5'(add_b)  + 5'(add_cin);
   assign {add_cout2, add_sum2} = 5'(add_a2) + 5'(add_b2) + 5'(add_cin2);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic exp4_t ref4(input logic [15:0] a, input logic [15:0] b, input logic cin);
      exp4_t       e;
      logic [16:0] u;
      int          s;
      u   = 17'(a) + 17'(b) + 17'(cin);
      s   = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.r = u[15:0];
      e.c = u[16];
      e.o = (s > 32767) || (s < -32768);
      return e;
   endfunction

   function automatic exp2_t ref2(input logic [7:0] a, input logic [7:0] b, input logic cin);
      exp2_t      e;
      logic [8:0] u;
      int         s;
      u   = 9'(a) + 9'(b) + 9'(cin);
      s   = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.r = u[7:0];
      e.c = u[8];
      e.o = (s > 127) || (s < -128);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop the oldest expectation whenever a result is handed off.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (q4.size() == 0) begin
            chk("res4_unexpected", 32'(res), 32'hFFFF_FFFF);
         end else begin
            m4_e = q4.pop_front();
            chk("res4",      32'(res),      32'(m4_e.r));
            chk("res4_cout", 32'(res_cout), 32'(m4_e.c));
            chk("res4_ovf",  32'(res_ovf),  32'(m4_e.o));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && res_valid2 && res_ready2) begin
         if (q2.size() == 0) begin
            chk("res2_unexpected", 32'(res2), 32'hFFFF_FFFF);
         end else begin
            m2_e = q2.pop_front();
            chk("res2",      32'(res2),      32'(m2_e.r));
            chk("res2_cout", 32'(res_cout2), 32'(m2_e.c));
            chk("res2_ovf",  32'(res_ovf2),  32'(m2_e.o));
         end
      end
   end

   always @(posedge clk) begin
      if (bp) begin
         #1 res_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic cin, input bit track);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("send4_ready_timeout", 32'(in_ready), 32'd1);
      op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
      if (track) q4.push_back(ref4(a, b, cin));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic cin);
      int t;
      t = 0;
      while (!in_ready2 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("send2_ready_timeout", 32'(in_ready2), 32'd1);
      op_a2 = a; op_b2 = b; op_cin2 = cin; in_valid2 = 1'b1;
      q2.push_back(ref2(a, b, cin));
      @(posedge clk); #1;
      in_valid2 = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((q4.size() != 0 || q2.size() != 0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk(nm, 32'(q4.size() + q2.size()), 32'd0);
   endtask

   initial begin
      int          n;
      logic [15:0] held;
      rst = 1'b1;
      in_valid = 1'b0; op_a = 16'd0; op_b = 16'd0; op_cin = 1'b0; res_ready = 1'b1;
      in_valid2 = 1'b0; op_a2 = 8'd0; op_b2 = 8'd0; op_cin2 = 1'b0; res_ready2 = 1'b1;

      #2;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res",       32'(res),       32'd0);
      chk("rst_add_a",     32'(add_a),     32'd0);
      chk("rst_in_ready2", 32'(in_ready2), 32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // LSB nibble first on the adder inputs, result four edges after accept.
      send4(16'h1234, 16'h4321, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("seq_add_a",     32'(add_a),     32'(4 - i));
         chk("seq_add_b",     32'(add_b),     32'(i + 1));
         chk("seq_res_valid", 32'(res_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("latency_first", 32'(res_valid), 32'd1);

      send4(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("carry_chain_add_cin", 32'(add_cin), 32'(i != 0));
      end
      send4(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      send4(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      send4(16'h8000, 16'h8000, 1'b0, 1'b1);
      drain("drain_directed");

      // Held result under backpressure; stray operands must be ignored.
      res_ready = 1'b0;
      send4(16'h1111, 16'h2222, 1'b0, 1'b1);
      n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid", 32'(res_valid), 32'd1);
      held = res;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 4);
         op_a = 16'hAAAA; op_b = 16'h5555;
         chk("bp_res_stable", 32'(res),       32'(held));
         chk("bp_res_valid",  32'(res_valid), 32'd1);
         chk("bp_in_ready",   32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_idle", 32'(in_ready), 32'd1);
      send4(16'h0A0A, 16'h0505, 1'b1, 1'b1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!res_valid && n < 20);
      chk("latency_accept", 32'(n), 32'd4);
      drain("drain_bp");

      // Asynchronous reset mid-computation discards the partial result.
      send4(16'h5555, 16'h5555, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      chk("arst_add_a",     32'(add_a),     32'd0);
      chk("arst_add_b",     32'(add_b),     32'd0);
      chk("arst_res",       32'(res),       32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_res_cout",  32'(res_cout),  32'd0);
      chk("arst_res_ovf",   32'(res_ovf),   32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_release_ready", 32'(in_ready), 32'd1);
      send4(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
      drain("drain_arst");

      // Random operands with random downstream backpressure.
      bp = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         send4(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain("drain_rand4");
      bp = 1'b0;
      @(posedge clk); #2 res_ready = 1'b1;

      // 8-bit build.
      @(posedge clk); #1;
      send2(8'hFF, 8'h01, 1'b1);
      for (int k = 0; k < 1000; k++) begin
         send2(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      drain("drain_rand2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
